// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bundle: decode/redirect control, imem load port and IF/ID head outputs.
// master = surrounding pipeline / loader, slave = fetch_queue_stage.
interface fetch_queue_stage_if #(
  parameter int PC_WIDTH    = 64,
  parameter int IMEM_DEPTH  = 64,
  parameter int QUEUE_DEPTH = 4
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                imem_wr_en;
  logic [AW-1:0]       imem_wr_addr;
  logic [31:0]         imem_wr_data;
  logic                out_valid;
  logic [PC_WIDTH-1:0] out_pc;
  logic [31:0]         out_instr;
  logic                out_fault;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]       queue_count;

  modport master (
    output stall, redirect_valid, redirect_pc, imem_wr_en, imem_wr_addr, imem_wr_data,
    input  out_valid, out_pc, out_instr, out_fault, fetch_pc, queue_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_wr_en, imem_wr_addr, imem_wr_data,
    output out_valid, out_pc, out_instr, out_fault, fetch_pc, queue_count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// IF stage: fetch PC + word-addressed imem feeding a small {pc, instr, fault} FIFO
// toward decode, with redirect flush and a fault state that halts fetch until redirected.
module fetch_queue_stage #(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  IMEM_DEPTH  = 64,
  parameter int                  QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic              clock,
  input  logic              reset,
  fetch_queue_stage_if.slave bus
);
  localparam int          AW  = $clog2(IMEM_DEPTH);
  localparam int          QW  = $clog2(QUEUE_DEPTH);
  localparam int          CW  = QW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic                fault;
  } entry_t;

  typedef enum logic {RUN, FAULT} state_e;

  logic [31:0]         imem [IMEM_DEPTH];
  entry_t              slot_q [QUEUE_DEPTH];
  logic [QW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  state_e              state_q, state_d;
  logic                push, pop, fetch_fault;
  entry_t              push_entry;

  // Misaligned or past the end of imem both fault; the entry carries a NOP.
  always_comb begin
    fetch_fault      = (fetch_pc_q[1:0] != 2'b00) ||
                       ((fetch_pc_q >> 2) >= PC_WIDTH'(IMEM_DEPTH));
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = fetch_fault ? NOP : imem[fetch_pc_q[AW+1:2]];
    push_entry.fault = fetch_fault;
  end

  // Redirect suppresses both queue operations; a full queue still accepts a push on a pop.
  always_comb begin
    pop  = (count_q != '0) && !bus.stall && !bus.redirect_valid;
    push = (state_q == RUN) && !bus.redirect_valid &&
           ((count_q < CW'(QUEUE_DEPTH)) || pop);
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    if (bus.redirect_valid) begin
      wr_ptr_d   = rd_ptr_q;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      state_d    = RUN;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // A faulting fetch freezes the PC so the fault address stays visible.
        if (fetch_fault) state_d    = FAULT;
        else             fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) slot_q[wr_ptr_q] <= push_entry;
    end
  end

  // Imem survives reset so a program can be loaded while the core is held.
  always_ff @(posedge clock) begin
    if (bus.imem_wr_en) imem[bus.imem_wr_addr] <= bus.imem_wr_data;
  end

  assign bus.out_valid   = (count_q != '0);
  assign bus.out_pc      = slot_q[rd_ptr_q].pc;
  assign bus.out_instr   = slot_q[rd_ptr_q].instr;
  assign bus.out_fault   = slot_q[rd_ptr_q].fault;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.queue_count = count_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: sequential fetch, stall fill, redirect flush,
// fault entries and asynchronous reset.
module tb_fetch_queue_stage;
  localparam int PW = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_queue_stage_if #(.PC_WIDTH(PW), .IMEM_DEPTH(64), .QUEUE_DEPTH(4)) bus ();

  fetch_queue_stage #(
    .PC_WIDTH(PW), .IMEM_DEPTH(64), .QUEUE_DEPTH(4), .RESET_PC('0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                      input logic flt);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_pc"},    bus.out_pc,         pc);
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'(ins));
    chk({tag, "_fault"}, 64'(bus.out_fault), 64'(flt));
  endtask

  task automatic redirect(input logic [63:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_wr_en = 1'b0; bus.imem_wr_addr = '0; bus.imem_wr_data = '0;
    #2;
    chk("rst_valid", 64'(bus.out_valid),   64'd0);
    chk("rst_count", 64'(bus.queue_count), 64'd0);
    chk("rst_fpc",   bus.fetch_pc,         64'h0);
    chk("rst_pc",    bus.out_pc,           64'h0);
    chk("rst_instr", 64'(bus.out_instr),   64'h0);
    chk("rst_fault", 64'(bus.out_fault),   64'h0);

    // Load the program while reset is held; words 4..63 get A000_00nn.
    for (int i = 0; i < 64; i++) begin
      bus.imem_wr_en   = 1'b1;
      bus.imem_wr_addr = 6'(i);
      bus.imem_wr_data = (i < 4) ? prog[i] : (32'hA000_0000 | 32'(i));
      step();
    end
    bus.imem_wr_en = 1'b0;
    reset = 1'b1;

    // 1: free-running fetch, one entry per cycle.
    step();
    for (int i = 0; i < 4; i++) begin
      head($sformatf("seq%0d", i), 64'(4 * i), prog[i], 1'b0);
      if (i < 3) step();
    end

    // 2: stall from the first valid cycle fills and saturates the queue.
    redirect(64'h0);
    chk("rd0_valid", 64'(bus.out_valid), 64'd0);
    bus.stall = 1'b1;
    step();
    head("st_head", 64'h0, prog[0], 1'b0);
    chk("st_cnt1", 64'(bus.queue_count), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk($sformatf("st_cnt%0d", i), 64'(bus.queue_count), 64'((i > 4) ? 4 : i));
      chk($sformatf("st_pc%0d", i),  bus.out_pc,            64'h0);
    end
    chk("st_fpc", bus.fetch_pc, 64'h10);
    bus.stall = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      head($sformatf("drain%0d", i), 64'(4 * i), prog[i], 1'b0);
      chk($sformatf("drain_cnt%0d", i), 64'(bus.queue_count), 64'd4);
    end

    // 3: redirect while full.
    redirect(64'h20);
    chk("r20_cnt",   64'(bus.queue_count), 64'd0);
    chk("r20_valid", 64'(bus.out_valid),   64'd0);
    chk("r20_fpc",   bus.fetch_pc,         64'h20);
    step();
    head("r20_head", 64'h20, 32'hA000_0008, 1'b0);

    // 4: misaligned target faults once and halts fetch until redirected.
    redirect(64'h22);
    chk("r22_fpc", bus.fetch_pc, 64'h22);
    step();
    head("r22_head", 64'h22, 32'h0000_0013, 1'b1);
    step();
    chk("r22_empty", 64'(bus.out_valid),   64'd0);
    step();
    chk("r22_hold",  64'(bus.queue_count), 64'd0);
    chk("r22_fpc2",  bus.fetch_pc,         64'h22);
    redirect(64'h0);
    step();
    head("resume", 64'h0, prog[0], 1'b0);

    // 5: run off the end of imem.
    redirect(64'hF0);
    step();
    head("end0", 64'hF0, 32'hA000_003C, 1'b0);
    step(); step(); step();
    head("end3", 64'hFC, 32'hA000_003F, 1'b0);
    step();
    head("oob", 64'h100, 32'h0000_0013, 1'b1);
    chk("oob_fpc", bus.fetch_pc, 64'h100);
    step();
    chk("oob_empty", 64'(bus.out_valid), 64'd0);
    chk("oob_fpc2",  bus.fetch_pc,       64'h100);

    // 6: asynchronous reset with three entries queued.
    redirect(64'h0);
    bus.stall = 1'b1;
    step(); step(); step();
    chk("ar_cnt3", 64'(bus.queue_count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid),   64'd0);
    chk("ar_cnt",   64'(bus.queue_count), 64'd0);
    chk("ar_fpc",   bus.fetch_pc,         64'h0);
    bus.stall = 1'b0;
    step();
    reset = 1'b1;
    step();
    head("imem_kept", 64'h0, prog[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
